// File: rtl/conv1_pkg.sv
// conv1_pkg: shared constants, default filter set and popcount helper for conv_layer1
package conv1_pkg;
   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int K      = 3;
   localparam int N_FILT = 8;
   localparam int THRESH = 5;
   // {W8,...,W1}; filter k occupies bits [9k-1:9k-9]
   localparam logic [9*N_FILT-1:0] WEIGHTS =
      {9'h054, 9'h111, 9'h092, 9'h038, 9'h155, 9'h0AA, 9'h000, 9'h1FF};
   function automatic logic [3:0] popcount9(input logic [K*K-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < K*K; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction
endpackage

// File: rtl/conv1_window.sv
// conv1_window: two line buffers plus a 3x3 sliding window over a raster pixel stream
//  clk          rising-edge clock
//  r_i, c_i     row/column of the pixel being sampled this cycle
//  pix_i        pixel being sampled this cycle
//  win_o        9-bit window, bit 3a+b = pixel(r-2+a, c-2+b)
//  win_valid_o  window lies fully inside the current frame rows/columns (r>=2, c>=2)
module conv1_window
   import conv1_pkg::*;
#(
   parameter int IMG_W = conv1_pkg::IMG_W,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = 5
) (
   input  logic             clk,
   input  logic [RW-1:0]    r_i,
   input  logic [CW-1:0]    c_i,
   input  logic             pix_i,
   output logic [K*K-1:0]   win_o,
   output logic             win_valid_o
);
   // lb1_q holds row r-1 and lb2_q row r-2, both indexed by column
   logic [IMG_W-1:0] lb1_q, lb2_q;
   // columns stored as {bottom, middle, top}; cur is the column completed by this sample
   logic [2:0] cur, col1_q, col0_q;
   assign cur = {pix_i, lb1_q[c_i], lb2_q[c_i]};
   always_ff @(posedge clk) begin
      lb1_q[c_i] <= pix_i;
      lb2_q[c_i] <= lb1_q[c_i];
      col1_q     <= cur;
      col0_q     <= col1_q;
   end
   assign win_o = {cur[2], col1_q[2], col0_q[2],
                   cur[1], col1_q[1], col0_q[1],
                   cur[0], col1_q[0], col0_q[0]};
   // stale columns from the previous row only appear while c<2, which is never valid
   assign win_valid_o = (r_i >= RW'(2)) && (c_i >= CW'(2));
endmodule

// File: rtl/conv_layer1.sv
// conv_layer1: binarized 3x3 conv layer, 8 XNOR-popcount filters over a 1-bit raster stream
//  clk                    rising-edge clock
//  rst_n                  synchronous reset, active high (name inherited)
//  pixel_in               one pixel per clock, raster order
//  conv1_out_1..8         filter results, held while valid_out_conv1 is low
//  valid_out_conv1        one-cycle pulse per 26x26 output position
//  frame_done             present only with CONV1_FRAME_DONE_EN; pulses with the last valid of a frame
module conv_layer1
   import conv1_pkg::*;
#(
   parameter int                    IMG_W   = conv1_pkg::IMG_W,
   parameter int                    IMG_H   = conv1_pkg::IMG_H,
   parameter int                    THRESH  = conv1_pkg::THRESH,
   parameter logic [9*N_FILT-1:0]   WEIGHTS = conv1_pkg::WEIGHTS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pixel_in,
   output logic conv1_out_1,
   output logic conv1_out_2,
   output logic conv1_out_3,
   output logic conv1_out_4,
   output logic conv1_out_5,
   output logic conv1_out_6,
   output logic conv1_out_7,
   output logic conv1_out_8,
   output logic valid_out_conv1
`ifdef CONV1_FRAME_DONE_EN
   ,
   output logic frame_done
`endif
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [3:0] TH = 4'(THRESH);
   logic [CW-1:0]     c_q, c_d;
   logic [RW-1:0]     r_q, r_d;
   logic              last_col, last_row;
   logic [K*K-1:0]    win;
   logic              win_valid;
   logic [N_FILT-1:0] hit, out_q;
   logic              valid_q;
   assign last_col = c_q == CW'(IMG_W-1);
   assign last_row = r_q == RW'(IMG_H-1);
   always_comb begin
      c_d = last_col ? '0 : c_q + 1'b1;
      r_d = !last_col ? r_q : last_row ? '0 : r_q + 1'b1;
   end
   conv1_window #(.IMG_W(IMG_W), .CW(CW), .RW(RW)) u_win (
      .clk         (clk),
      .r_i         (r_q),
      .c_i         (c_q),
      .pix_i       (pixel_in),
      .win_o       (win),
      .win_valid_o (win_valid)
   );
   always_comb begin
      hit = '0;
      for (int k = 0; k < N_FILT; k++) hit[k] = popcount9(~(WEIGHTS[9*k +: 9] ^ win)) >= TH;
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         c_q     <= '0;
         r_q     <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         c_q     <= c_d;
         r_q     <= r_d;
         valid_q <= win_valid;
         if (win_valid) out_q <= hit;
      end
   end
   assign {conv1_out_8, conv1_out_7, conv1_out_6, conv1_out_5,
           conv1_out_4, conv1_out_3, conv1_out_2, conv1_out_1} = out_q;
   assign valid_out_conv1 = valid_q;
`ifdef CONV1_FRAME_DONE_EN
   logic fd_q;
   always_ff @(posedge clk) fd_q <= rst_n ? 1'b0 : (last_row && last_col);
   assign frame_done = fd_q;
`endif
endmodule

// File: tb/tb_conv_layer1.sv
// tb_conv_layer1: directed self-checking bench for conv_layer1
module tb_conv_layer1;
   logic clk = 1'b0;
   logic rst_n, pixel_in;
   logic o1, o2, o3, o4, o5, o6, o7, o8, valid;
   logic [7:0] outv, last;
   int checks = 0, failures = 0;
`ifdef CONV1_FRAME_DONE_EN
   logic fd;
`endif
   always #5 clk = ~clk;
   assign outv = {o8, o7, o6, o5, o4, o3, o2, o1};
   conv_layer1 dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pixel_in        (pixel_in),
      .conv1_out_1     (o1),
      .conv1_out_2     (o2),
      .conv1_out_3     (o3),
      .conv1_out_4     (o4),
      .conv1_out_5     (o5),
      .conv1_out_6     (o6),
      .conv1_out_7     (o7),
      .conv1_out_8     (o8),
      .valid_out_conv1 (valid)
`ifdef CONV1_FRAME_DONE_EN
      ,
      .frame_done      (fd)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // pat 0: checkerboard (r+c)%2, 1: all zeros, 2: all ones
   task automatic run_frame(input int pat, input string tag, output int nv);
      int nbad, nstray, first, nfdbad;
      logic [7:0] e, res1, res2;
      nv = 0; nbad = 0; nstray = 0; first = -1; nfdbad = 0; res1 = 'x; res2 = 'x;
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++) begin
            pixel_in = pat == 0 ? 1'((r + c) % 2) : (pat == 2);
            @(posedge clk); #1;
            e = pat == 0 ? (((r + c) % 2 == 0) ? 8'h36 : 8'hC9) : pat == 1 ? 8'hF6 : 8'h09;
            if (valid !== (r >= 2 && c >= 2)) nstray++;
            if (valid === 1'b1) begin
               nv++;
               if (first < 0) begin first = r * 28 + c + 1; res1 = outv; end
               else if (nv == 2) res2 = outv;
               if (outv !== e) nbad++;
               last = outv;
            end else if (outv !== last) nbad++;
`ifdef CONV1_FRAME_DONE_EN
            if (fd !== (r == 27 && c == 27)) nfdbad++;
`endif
         end
      end
      check({tag, "_valids"}, nv, 676);
      check({tag, "_stray"}, nstray, 0);
      check({tag, "_values"}, nbad, 0);
      check({tag, "_first_cycle"}, first, 59);
      if (pat == 0) begin
         check({tag, "_res1"}, {24'd0, res1}, 32'h36);
         check({tag, "_res2"}, {24'd0, res2}, 32'hC9);
      end
`ifdef CONV1_FRAME_DONE_EN
      check({tag, "_frame_done"}, nfdbad, 0);
`endif
   endtask
   initial begin
      int n, na, nb;
      rst_n = 1'b1; pixel_in = 1'b0; last = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, valid}, 0);
      check("rst_out", {24'd0, outv}, 0);
`ifdef CONV1_FRAME_DONE_EN
      check("rst_fd", {31'd0, fd}, 0);
`endif
      rst_n = 1'b0;
      run_frame(0, "cb", n);
      run_frame(1, "zeros", n);
      run_frame(2, "ones", n);
      for (int i = 0; i < 300; i++) begin
         pixel_in = 1'((i / 28 + i % 28) % 2);
         @(posedge clk); #1;
      end
      check("mid_valid_before", {31'd0, valid}, 1);
      check("mid_out_before", {24'd0, outv}, 32'hC9);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_valid", {31'd0, valid}, 0);
      check("mid_rst_out", {24'd0, outv}, 0);
      last = '0;
      rst_n = 1'b0;
      run_frame(0, "cb_a", na);
      run_frame(0, "cb_b", nb);
      check("b2b_total", na + nb, 1352);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
